imsic_msi_injector: RTL

// - Multi-hart MSI injection engine for the AIA integration bench; generalised successor of the single-shot AXI-lite MSI write path.
// - Per-hart request queues are arbitrated round-robin; each request becomes one AXI4-Lite write to that hart's IMSIC file:

---
 rtl/imsic_msi_inj_pkg.sv | 40 ++++
 rtl/imsic_msi_injector_fifo.sv | 60 ++++++
 rtl/imsic_msi_injector.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/imsic_msi_inj_pkg.sv
// ---------------------------------------------------------------------------
// imsic_msi_inj_pkg
// Shared types and constants for the IMSIC MSI injector:
//   inj_state_e  - injector FSM states
//   msi_req_t    - queued request (EIID + guest file index), sized to the
//                  widest supported fields; the top zero-extends into it
//   AXI_RESP_*   - AXI4-Lite B response encodings
//   resp_is_err  - true for SLVERR/DECERR
//   sat_inc16    - saturating 16-bit increment for the drop counter
// ---------------------------------------------------------------------------
package imsic_msi_inj_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } inj_state_e;

  localparam int unsigned MsiEiidMaxW  = 16;
  localparam int unsigned MsiGuestMaxW = 8;

  typedef struct packed {
    logic [MsiEiidMaxW-1:0]  eiid;
    logic [MsiGuestMaxW-1:0] guest;
  } msi_req_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/imsic_msi_injector_fifo.sv
// ---------------------------------------------------------------------------
// msi_inj_fifo
// Synchronous single-clock FIFO, one per hart request channel.
// Ports:
//   i_clk, ni_rst     clock, synchronous active-low reset (empties the queue)
//   i_push, i_data    write strobe/data; ignored while full
//   i_pop             read strobe; ignored while empty
//   o_data            head entry (valid while !o_empty)
//   o_full, o_empty   occupancy flags
// Depth must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module msi_inj_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             i_clk,
  input  logic             ni_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign o_full  = (cnt_q == CntW'(Depth));
  assign o_empty = (cnt_q == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = mem_q[rd_q];

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrW'(1);
      if (do_pop)  rd_q <= rd_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/imsic_msi_injector.sv
// ---------------------------------------------------------------------------
// imsic_msi_injector
// Multi-hart MSI injection engine. Per-hart request queues are arbitrated
// round-robin; each request becomes one AXI4-Lite write of the EIID to
//   BaseAddr + hart*HartStride + guest*GuestStride.
// Ports:
//   i_clk, ni_rst                      clock, synchronous active-low reset
//   i_req_valid/o_req_ready            per-hart enqueue handshake
//   i_req_eiid, i_req_guest            per-hart request payload (packed)
//   o_aw_*/i_aw_ready, o_w_*/i_w_ready AXI4-Lite write address/data
//   i_b_valid/o_b_ready/i_b_resp       AXI4-Lite write response
//   o_busy                             FSM active or any queue non-empty
//   o_err_cnt                          saturating count of dropped writes
// Build option: define MSI_INJ_RETRY_EN to retry an error response up to
// MaxRetry times before dropping; otherwise an error drops at once.
// The guest field is at least one bit wide even when NrGuests is 0.
// ---------------------------------------------------------------------------
module imsic_msi_injector
  import imsic_msi_inj_pkg::*;
#(
  parameter int unsigned NrHarts     = 4,
  parameter int unsigned NrGuests    = 0,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned EiidWidth   = 11,
  parameter logic [63:0] BaseAddr    = 64'h2400_0000,
  parameter logic [63:0] HartStride  = 64'h1000,
  parameter logic [63:0] GuestStride = 64'h1000,
  parameter int unsigned MaxRetry    = 3,
  localparam int unsigned GuestWidth = (NrGuests > 0) ? $clog2(NrGuests + 1) : 1
) (
  input  logic                            i_clk,
  input  logic                            ni_rst,
  input  logic [NrHarts-1:0]              i_req_valid,
  output logic [NrHarts-1:0]              o_req_ready,
  input  logic [NrHarts*EiidWidth-1:0]    i_req_eiid,
  input  logic [NrHarts*GuestWidth-1:0]   i_req_guest,
  output logic                            o_aw_valid,
  input  logic                            i_aw_ready,
  output logic [AddrWidth-1:0]            o_aw_addr,
  output logic                            o_w_valid,
  input  logic                            i_w_ready,
  output logic [DataWidth-1:0]            o_w_data,
  output logic [DataWidth/8-1:0]          o_w_strb,
  input  logic                            i_b_valid,
  output logic                            o_b_ready,
  input  logic [1:0]                      i_b_resp,
  output logic                            o_busy,
  output logic [15:0]                     o_err_cnt
);

  localparam int unsigned HartW = (NrHarts > 1) ? $clog2(NrHarts) : 1;
  localparam int unsigned ReqW  = $bits(msi_req_t);

  logic [NrHarts-1:0] q_full, q_empty, q_pop;
  logic [ReqW-1:0]    q_dout [NrHarts];

  inj_state_e           state_q;
  logic [HartW-1:0]     rr_ptr_q;
  logic                 aw_valid_q, w_valid_q, b_ready_q;
  logic [AddrWidth-1:0] aw_addr_q;
  logic [DataWidth-1:0] w_data_q;
  logic [15:0]          err_cnt_q;
`ifdef MSI_INJ_RETRY_EN
  localparam int unsigned RetryW = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1;
  logic [RetryW-1:0]    retry_cnt_q;
`endif

  // Per-hart request queues
  for (genvar h = 0; h < NrHarts; h++) begin : g_chan
    msi_req_t push_req;

    always_comb begin
      push_req       = '0;
      push_req.eiid  = MsiEiidMaxW'(i_req_eiid[h*EiidWidth +: EiidWidth]);
      push_req.guest = MsiGuestMaxW'(i_req_guest[h*GuestWidth +: GuestWidth]);
    end

    msi_inj_fifo #(
      .Width (ReqW),
      .Depth (FifoDepth)
    ) u_fifo (
      .i_clk   (i_clk),
      .ni_rst  (ni_rst),
      .i_push  (i_req_valid[h]),
      .i_data  (push_req),
      .i_pop   (q_pop[h]),
      .o_data  (q_dout[h]),
      .o_full  (q_full[h]),
      .o_empty (q_empty[h])
    );

    assign o_req_ready[h] = !q_full[h];
  end

  // Round-robin arbiter: first non-empty queue at or after the pointer
  logic             win_valid;
  logic [HartW-1:0] win_idx;
  logic [HartW-1:0] ptr_next;
  logic             grant;
  int unsigned      cand;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NrHarts; i++) begin
      cand = (32'(rr_ptr_q) + i) % NrHarts;
      if (!win_valid && !q_empty[cand]) begin
        win_valid = 1'b1;
        win_idx   = HartW'(cand);
      end
    end
  end

  assign grant    = (state_q == IDLE) && win_valid;
  assign ptr_next = (win_idx == HartW'(NrHarts - 1)) ? '0 : win_idx + HartW'(1);

  always_comb begin
    q_pop = '0;
    for (int unsigned h = 0; h < NrHarts; h++) begin
      q_pop[h] = grant && (32'(win_idx) == h);
    end
  end

  msi_req_t             win_req;
  logic [AddrWidth-1:0] grant_addr;
  logic [DataWidth-1:0] grant_data;

  always_comb begin
    win_req    = msi_req_t'(q_dout[win_idx]);
    grant_addr = AddrWidth'(BaseAddr)
               + AddrWidth'(win_idx) * AddrWidth'(HartStride)
               + AddrWidth'(win_req.guest) * AddrWidth'(GuestStride);
    grant_data = DataWidth'(win_req.eiid);
  end

  // AW and W complete independently; both must be done to leave ADDR
  logic aw_done, w_done;
  assign aw_done = !aw_valid_q || i_aw_ready;
  assign w_done  = !w_valid_q || i_w_ready;

  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      err_cnt_q   <= '0;
`ifdef MSI_INJ_RETRY_EN
      retry_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            aw_addr_q   <= grant_addr;
            w_data_q    <= grant_data;
            aw_valid_q  <= 1'b1;
            w_valid_q   <= 1'b1;
            rr_ptr_q    <= ptr_next;
            state_q     <= ADDR;
`ifdef MSI_INJ_RETRY_EN
            retry_cnt_q <= '0;
`endif
          end
        end
        ADDR: begin
          if (aw_valid_q && i_aw_ready) aw_valid_q <= 1'b0;
          if (w_valid_q && i_w_ready)   w_valid_q  <= 1'b0;
          if (aw_done && w_done) begin
            b_ready_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (i_b_valid) begin
            b_ready_q <= 1'b0;
            if (resp_is_err(i_b_resp)) begin
`ifdef MSI_INJ_RETRY_EN
              if (retry_cnt_q < RetryW'(MaxRetry)) begin
                // Replay the held addr/data unchanged
                retry_cnt_q <= retry_cnt_q + RetryW'(1);
                aw_valid_q  <= 1'b1;
                w_valid_q   <= 1'b1;
                state_q     <= ADDR;
              end else begin
                err_cnt_q <= sat_inc16(err_cnt_q);
                state_q   <= IDLE;
              end
`else
              err_cnt_q <= sat_inc16(err_cnt_q);
              state_q   <= IDLE;
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_aw_valid = aw_valid_q;
  assign o_aw_addr  = aw_addr_q;
  assign o_w_valid  = w_valid_q;
  assign o_w_data   = w_data_q;
  assign o_w_strb   = '1;
  assign o_b_ready  = b_ready_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_busy     = (state_q != IDLE) || !(&q_empty);

endmodule
